// File: rtl/imem_loader.sv
// imem_loader: receives a big-endian byte stream over valid/ready, assembles
// 32-bit instruction words and writes them to the instruction memory. Word
// addresses run up from BASE_ADDR. The CPU is held while a load is running.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h00000004,
  parameter int          MAX_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        we,
  output logic [31:0] wa,
  output logic [31:0] wd,
  output logic        busy,
  output logic        cpu_hold,
  output logic        done,
  output logic        err,
  output logic [31:0] checksum
);

  localparam int IDXW = $clog2(MAX_WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t          state_r;
  state_t          state_nx_s;
  logic [1:0]      bcnt_r;
  logic [IDXW-1:0] idx_r;
  logic [31:0]     count_r;
  logic [31:0]     shift_r;
  logic [31:0]     wa_r;
  logic [31:0]     wd_r;
  logic [31:0]     checksum_r;

  logic            in_ready_s;
  logic            accept_s;
  logic            last_byte_s;
  logic            start_take_s;
  logic [31:0]     assembled_s;
  logic [IDXW-1:0] idx_inc_s;
  logic            last_word_s;
  logic            hdr_bad_s;

  // Handshake and word-assembly helpers, all decoded from registered state.
  always_comb begin
    in_ready_s   = (state_r == S_HDR) || (state_r == S_DATA);
    accept_s     = in_valid && in_ready_s;
    last_byte_s  = (bcnt_r == 2'd3);
    start_take_s = start && !abort &&
                   ((state_r == S_IDLE) || (state_r == S_DONE) || (state_r == S_ERR));
    assembled_s  = {shift_r[23:0], in_data};
    idx_inc_s    = idx_r + {{(IDXW-1){1'b0}}, 1'b1};
    last_word_s  = (32'(idx_inc_s) == count_r);
    hdr_bad_s    = (assembled_s == 32'd0) || (assembled_s > 32'(MAX_WORDS));
  end

  // Next-state decode; abort always wins over start and stream progress.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start_take_s) state_nx_s = S_HDR;
        else              state_nx_s = S_IDLE;
      end
      S_HDR: begin
        if (abort)                          state_nx_s = S_IDLE;
        else if (accept_s && last_byte_s)   state_nx_s = hdr_bad_s ? S_ERR : S_DATA;
        else                                state_nx_s = S_HDR;
      end
      S_DATA: begin
        if (abort)                          state_nx_s = S_IDLE;
        else if (accept_s && last_byte_s)   state_nx_s = S_WRITE;
        else                                state_nx_s = S_DATA;
      end
      S_WRITE: begin
        if (abort)            state_nx_s = S_IDLE;
        else if (last_word_s) state_nx_s = S_DONE;
        else                  state_nx_s = S_DATA;
      end
      S_DONE, S_ERR: begin
        if (abort)             state_nx_s = S_IDLE;
        else if (start_take_s) state_nx_s = S_HDR;
        else                   state_nx_s = state_r;
      end
      default: state_nx_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= S_IDLE;
    else        state_r <= state_nx_s;
  end

  // Datapath: byte shifting, header capture, write staging and checksum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_r     <= 2'd0;
      idx_r      <= '0;
      count_r    <= 32'd0;
      shift_r    <= 32'd0;
      wa_r       <= 32'd0;
      wd_r       <= 32'd0;
      checksum_r <= 32'd0;
    end else if (start_take_s) begin
      bcnt_r     <= 2'd0;
      idx_r      <= '0;
      shift_r    <= 32'd0;
      checksum_r <= 32'd0;
    end else if (abort) begin
      // Any partially assembled word is dropped.
      bcnt_r <= 2'd0;
    end else if (accept_s) begin
      shift_r <= assembled_s;
      bcnt_r  <= bcnt_r + 2'd1;
      if (last_byte_s && (state_r == S_HDR)) begin
        count_r <= assembled_s;
      end
      if (last_byte_s && (state_r == S_DATA)) begin
        wd_r <= assembled_s;
        wa_r <= BASE_ADDR + (32'(idx_r) << 2);
      end
    end else if (state_r == S_WRITE) begin
      checksum_r <= checksum_r ^ wd_r;
      idx_r      <= idx_inc_s;
    end
  end

  // Output decode; the write strobe is killed by an abort in the WRITE cycle.
  always_comb begin
    in_ready = in_ready_s;
    we       = (state_r == S_WRITE) && !abort;
    wa       = wa_r;
    wd       = wd_r;
    busy     = (state_r == S_HDR) || (state_r == S_DATA) || (state_r == S_WRITE);
    cpu_hold = busy;
    done     = (state_r == S_DONE);
    err      = (state_r == S_ERR);
    checksum = checksum_r;
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven loads with random data
// and stream bubbles against a reference model, plus hand-written corner cases.
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h00000004;
  localparam int          MAXW = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, we, busy, cpu_hold, done, err;
  logic [31:0] wa, wd, checksum;

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .we(we), .wa(wa), .wd(wd), .busy(busy), .cpu_hold(cpu_hold),
    .done(done), .err(err), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  stim[$];
  logic [31:0] got_wa[$], got_wd[$];
  logic [31:0] exp_wa[$], exp_wd[$];
  logic [31:0] exp_cs;
  bit          exp_err;

  typedef struct {
    logic [31:0] hdr;
    int          gmax;
    bit          want_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Capture every write strobe; in_ready must be low in a WRITE cycle.
  always @(negedge clk) begin
    if (rst_n && we) begin
      got_wa.push_back(wa);
      got_wd.push_back(wd);
      n_cmp++;
      if (in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL ready_in_write: got %b expected 0", in_ready);
      end
    end
  end

  // Reference model: interpret the byte stream by the loader's rules.
  task automatic build_expected();
    logic [31:0] cnt, w;
    exp_wa.delete(); exp_wd.delete();
    exp_cs = 32'd0;
    cnt = {stim[0], stim[1], stim[2], stim[3]};
    exp_err = (cnt == 32'd0) || (cnt > 32'(MAXW));
    if (!exp_err) begin
      for (int i = 0; i < int'(cnt); i++) begin
        w = {stim[4+4*i], stim[5+4*i], stim[6+4*i], stim[7+4*i]};
        exp_wa.push_back(BASE + 32'(4 * i));
        exp_wd.push_back(w);
        exp_cs = exp_cs ^ w;
      end
    end
  endtask

  task automatic make_stim(input logic [31:0] hdr);
    stim.delete();
    for (int k = 3; k >= 0; k--) stim.push_back(hdr[8*k +: 8]);
    if (hdr != 32'd0 && hdr <= 32'(MAXW))
      for (int i = 0; i < 4 * int'(hdr); i++) stim.push_back(8'($urandom));
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    got_wa.delete(); got_wd.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gaps);
    int guard;
    in_valid = 1'b0;
    repeat (gaps) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = b;
    guard = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      guard++;
      if (guard > 50) begin
        chk("ready_timeout", 32'(in_ready), 32'd1);
        break;
      end
    end
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  task automatic wait_end();
    int k = 0;
    while (!(done || err) && k < 40) begin @(negedge clk); k++; end
    chk("end_timeout", 32'(done || err), 32'd1);
    @(negedge clk);
  endtask

  task automatic compare_writes(input string tag);
    chk({tag, "_nwrites"}, 32'(got_wa.size()), 32'(exp_wa.size()));
    for (int i = 0; i < got_wa.size() && i < exp_wa.size(); i++) begin
      chk({tag, "_wa"}, got_wa[i], exp_wa[i]);
      chk({tag, "_wd"}, got_wd[i], exp_wd[i]);
    end
  endtask

  task automatic run_load(input string tag, input int gmax);
    build_expected();
    pulse_start();
    chk({tag, "_busy_at_start"}, 32'(busy), 32'd1);
    foreach (stim[i]) send_byte(stim[i], $urandom_range(0, gmax));
    wait_end();
    compare_writes(tag);
    chk({tag, "_err"},  32'(err),  32'(exp_err));
    chk({tag, "_done"}, 32'(done), 32'(!exp_err));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    if (!exp_err) chk({tag, "_checksum"}, checksum, exp_cs);
  endtask

  task automatic set_two_word();
    logic [7:0] seq [12] = '{8'h00, 8'h00, 8'h00, 8'h02,
                              8'hE3, 8'hA0, 8'h00, 8'h00,
                              8'hE3, 8'hA0, 8'h40, 8'h04};
    stim.delete();
    foreach (seq[i]) stim.push_back(seq[i]);
  endtask

  task automatic check_two_word(input string tag);
    chk({tag, "_n"}, 32'(got_wa.size()), 32'd2);
    if (got_wa.size() == 2) begin
      chk({tag, "_wa0"}, got_wa[0], 32'h00000004);
      chk({tag, "_wd0"}, got_wd[0], 32'hE3A00000);
      chk({tag, "_wa1"}, got_wa[1], 32'h00000008);
      chk({tag, "_wd1"}, got_wd[1], 32'hE3A04004);
    end
    chk({tag, "_cs"}, checksum, 32'h00004004);
    chk({tag, "_done"}, 32'(done), 32'd1);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{32'd1,          0, 1'b0};
    vecs[1] = '{32'd3,          2, 1'b0};
    vecs[2] = '{32'd64,         1, 1'b0};
    vecs[3] = '{32'd65,         0, 1'b1};
    vecs[4] = '{32'd0,          1, 1'b1};
    vecs[5] = '{32'h80000001,   0, 1'b1};
    vecs[6] = '{32'h00010002,   0, 1'b1};
    vecs[7] = '{32'd7,          3, 1'b0};

    // Reset state.
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_hold",  32'(cpu_hold), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_err",   32'(err), 32'd0);
    chk("rst_cs",    checksum, 32'd0);
    chk("rst_wa",    wa, 32'd0);

    // Two-word load, no gaps, exact values.
    set_two_word();
    run_load("two", 0);
    check_two_word("two_fixed");

    // Bad headers and err clearing by start.
    stim.delete(); stim = '{8'h00, 8'h00, 8'h00, 8'h00};
    run_load("hdr0", 0);
    stim.delete(); stim = '{8'h00, 8'h00, 8'h00, 8'h41};
    run_load("hdr65", 0);
    pulse_start();
    chk("err_cleared", 32'(err), 32'd0);
    chk("hdr_after_err_ready", 32'(in_ready), 32'd1);
    #1 abort = 1'b1; @(posedge clk); #1 abort = 1'b0;

    // Two-word load with random bubbles.
    set_two_word();
    run_load("gaps", 3);
    check_two_word("gaps_fixed");

    // Table of randomized loads against the model.
    foreach (vecs[v]) begin
      make_stim(vecs[v].hdr);
      run_load($sformatf("vec%0d", v), vecs[v].gmax);
      chk($sformatf("vec%0d_table_err", v), 32'(err), 32'(vecs[v].want_err));
    end

    // Abort after header (count 3) and two data bytes.
    pulse_start();
    stim.delete(); stim = '{8'h00, 8'h00, 8'h00, 8'h03, 8'h11, 8'h22};
    foreach (stim[i]) send_byte(stim[i], 0);
    #1 abort = 1'b1; @(posedge clk); #1 abort = 1'b0;
    chk("abort_busy",  32'(busy), 32'd0);
    chk("abort_ready", 32'(in_ready), 32'd0);
    chk("abort_done",  32'(done), 32'd0);
    repeat (3) @(negedge clk);
    chk("abort_nowrite", 32'(got_wa.size()), 32'd0);
    make_stim(32'd2);
    run_load("after_abort", 1);

    // Abort landing in the WRITE cycle.
    pulse_start();
    stim.delete(); stim = '{8'h00, 8'h00, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    foreach (stim[i]) send_byte(stim[i], 0);
    #1 abort = 1'b1;
    @(negedge clk);
    chk("abort_write_we", 32'(we), 32'd0);
    @(posedge clk); #1 abort = 1'b0;
    chk("abort_write_busy", 32'(busy), 32'd0);
    chk("abort_write_nowrite", 32'(got_wa.size()), 32'd0);

    // Start pulsed during DATA is ignored.
    make_stim(32'd2);
    build_expected();
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(stim[i], 0);
    start = 1'b1; @(posedge clk); #1 start = 1'b0;
    for (int i = 6; i < stim.size(); i++) send_byte(stim[i], 0);
    wait_end();
    compare_writes("start_busy");
    chk("start_busy_done", 32'(done), 32'd1);
    chk("start_busy_cs", checksum, exp_cs);

    // Asynchronous reset in the middle of DATA.
    pulse_start();
    stim.delete(); stim = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h55};
    foreach (stim[i]) send_byte(stim[i], 0);
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_hold", 32'(cpu_hold), 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd0);
    chk("arst_we", 32'(we), 32'd0);
    chk("arst_wa", wa, 32'd0);
    chk("arst_wd", wd, 32'd0);
    chk("arst_cs", checksum, 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("arst_idle_ready", 32'(in_ready), 32'd0);
    chk("arst_idle_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that writes the processor's instruction memory. It accepts a byte stream over a valid/ready handshake and assembles it big-endian into 32-bit instruction words, then issues one-cycle write strobes to the instruction memory's write port. Word addresses run sequentially from `BASE_ADDR` upward. It sits between the host-side byte source (UART/debug bridge) and the instruction memory, and it holds the CPU stalled while a load is in progress.

## Interface
- `BASE_ADDR`, 32'h00000004: byte address of the first instruction written.
- `MAX_WORDS`, 64: largest accepted word count. A header above this is an error.
- `clk`  in  1  system clock, rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin a load. Honoured only in IDLE, DONE or ERR.
- `abort`  in  1  cancel the load in progress and return to IDLE.
- `in_valid`  in  1  `in_data` is valid.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `we`  out  1  instruction-memory write strobe, one cycle per word.
- `wa`  out  32  write byte address.
- `wd`  out  32  write data.
- `busy`  out  1  load in progress (HDR, DATA or WRITE).
- `cpu_hold`  out  1  equals `busy`. The CPU fetch stage stalls while this is high.
- `done`  out  1  last load completed. Held until the next `start`.
- `err`  out  1  header rejected. Held until the next `start`.
- `checksum`  out  32  XOR of all words written by the current or last load.

## Operation
- **States:** IDLE, HDR, DATA, WRITE, DONE, ERR.
- **Byte transfer:** a byte is accepted on a rising edge where `in_valid && in_ready`. `in_ready` is a pure decode of the state: 1 in HDR and DATA, 0 otherwise.
- **Byte order:** first byte is bits [31:24] and fourth byte is bits [7:0], for both the header and data words.
- **IDLE/DONE/ERR + `start`:**
  - go to HDR;
  - clear byte counter, word index, `checksum`, `done` and `err`.
- **HDR:** collects 4 bytes into `count`. On the 4th byte:
  - if `count == 0` or `count > MAX_WORDS`, go to ERR;
  - otherwise go to DATA.
- **DATA:** collects 4 bytes into the word register. On the 4th byte, go to WRITE.
- **WRITE** (exactly one cycle):
  - `we = 1`, `wa = BASE_ADDR + (idx << 2)` (32-bit, wraps modulo 2^32), `wd = word`;
  - `checksum ^= word`, `idx++`;
  - if the new `idx == count`, go to DONE; otherwise go to DATA.
- **`abort`:** in any non-IDLE state, go to IDLE next edge.
  - A partial word is discarded and no write is issued, including when `abort` arrives in the WRITE cycle (`we` is gated off).
  - `done` and `err` are cleared.
- **Priority:** `abort` > `start`. `start` in HDR, DATA or WRITE is ignored.
- **`idx` width:** `$clog2(MAX_WORDS+1)` bits. `count` is compared at the full 32 bits.

## Timing
- **Reset values:** state IDLE and all outputs 0 (`in_ready`, `we`, `wa`, `wd`, `busy`, `cpu_hold`, `done`, `err`, `checksum`). Reset takes effect immediately, mid-load included.
- **Start:** `start` sampled at edge N makes `busy` and `in_ready` high from N (registered state, visible after edge N).
- **Write latency:** the 4th data byte is accepted at edge M. `we`, `wa` and `wd` are valid in the cycle after M and the memory captures them at edge M+1. `in_ready` is 0 during that cycle.
- **Throughput:** minimum 5 cycles per word. Gaps in `in_valid` only stretch DATA/HDR.
- **Completion:** `done` rises the cycle after the final WRITE. `checksum` is final when `done` = 1.
- **Registered outputs:** `wa` and `wd` hold their last values outside WRITE. Only `we` qualifies them.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-cycle during DATA → all outputs 0 without waiting for an edge. After release, state is IDLE and `in_ready` = 0.
- **Two-word load:** `start`, then bytes 00 00 00 02, E3 A0 00 00, E3 A0 40 04 →
  - `we` at `wa` = 0x4 with `wd` = 0xE3A00000;
  - `we` at `wa` = 0x8 with `wd` = 0xE3A04004;
  - then `done` = 1, `busy` = 0, `checksum` = 0x00004004.
- **Bad headers:** header 00 00 00 00 → `err` = 1 with no `we`. Header 00 00 00 41 (65 > 64) → `err` = 1. A following `start` clears `err`.
- **Stream gaps:** the two-word load with random `in_valid` bubbles → identical writes and checksum, and `in_ready` = 0 during each WRITE cycle.
- **Abort:** after the header (count 3) and 2 data bytes, pulse `abort` → no `we`, state IDLE next cycle, `busy` = 0. A fresh load then writes starting at 0x4.
- **Abort in WRITE / start while busy:** `abort` in the WRITE cycle → `we` stays 0. `start` pulsed while in DATA → ignored, and the load completes normally.
